// File: rtl/shift_unit_if.sv
// Request/result bundle between the control unit and the iterative shift unit.
// The control unit drives it as master; the shift unit drives it as slave.
interface shift_unit_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [2:0]         shiftOp;
   logic [WIDTH-1:0]   w_shiftIn;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   w_shiftOut;
   logic               busy;
   logic               done;

   modport master (
      output start,
      output shiftOp,
      output w_shiftIn,
      output shamt,
      input  w_shiftOut,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  shiftOp,
      input  w_shiftIn,
      input  shamt,
      output w_shiftOut,
      output busy,
      output done
   );
endinterface

// File: rtl/shift_unit.sv
// Iterative one-bit-per-clock shifter: capture, shift shamt times, pulse done.
// The result register holds its value in IDLE until the next accepted start.
module shift_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic        clock,
   input logic        reset,
   shift_unit_if.slave bus
);

   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;
   localparam logic [2:0] OP_ROL = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   data;
   logic [SHAMT_W-1:0] count;
   logic [2:0]         op;

   // One single-bit step; unknown codes hold so no-op timing matches a shift.
   function automatic logic [WIDTH-1:0] step(
      input logic [WIDTH-1:0] d,
      input logic [2:0]       o
   );
      logic [WIDTH-1:0] r;
      r = d;
      case (o)
         OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
         OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
         OP_ROR:  r = {d[0], d[WIDTH-1:1]};
         OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
         default: r = d;
      endcase
      return r;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         data  <= '0;
         count <= '0;
         op    <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  data  <= bus.w_shiftIn;
                  count <= bus.shamt;
                  op    <= bus.shiftOp;
                  state <= (bus.shamt != '0) ? SHIFT : DONE;
               end
            end
            SHIFT: begin
               data  <= step(data, op);
               count <= count - 1'b1;
               if (count == SHAMT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.w_shiftOut = data;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_shift_unit;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   shift_unit_if bus();

   shift_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic start_op(
      input logic [2:0]  op,
      input logic [31:0] a,
      input logic [4:0]  s
   );
      bus.start     = 1'b1;
      bus.shiftOp   = op;
      bus.w_shiftIn = a;
      bus.shamt     = s;
      @(posedge clock); #1;
      bus.start     = 1'b0;
      bus.w_shiftIn = 32'h5A5A_A5A5;
      bus.shamt     = 5'd7;
   endtask

   // Cycle index (1 = cycle after capture) at which done is seen; 0 on timeout.
   task automatic wait_done(output int cyc, output int busy_n);
      cyc = 0;
      busy_n = 0;
      for (int i = 1; i <= 64; i++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin
            cyc = i;
            break;
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset;
      start_op(3'b001, 32'h0000_00F1, 5'd4);
      @(posedge clock); #3;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.w_shiftOut !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: out=%h busy=%b done=%b want 0/0/0",
                  bus.w_shiftOut, bus.busy, bus.done);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checks++;
         if (bus.w_shiftOut !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle[%0d]: out=%h busy=%b done=%b want 0/0/0",
                     i, bus.w_shiftOut, bus.busy, bus.done);
         end
      end
   endtask

   task automatic test_sll;
      int cyc, bn;
      start_op(3'b001, 32'h0000_00F1, 5'd4);
      wait_done(cyc, bn);
      checks++;
      if (cyc !== 5) begin
         failures++;
         $display("FAIL sll_latency: done at %0d want 5", cyc);
      end
      checks++;
      if (bn !== 5) begin
         failures++;
         $display("FAIL sll_busy: busy cycles %0d want 5", bn);
      end
      checks++;
      if (bus.w_shiftOut !== 32'h0000_0F10) begin
         failures++;
         $display("FAIL sll_result: got %h want 00000f10", bus.w_shiftOut);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         checks++;
         if (bus.w_shiftOut !== 32'h0000_0F10 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL sll_hold[%0d]: out=%h busy=%b done=%b want 00000f10/0/0",
                     i, bus.w_shiftOut, bus.busy, bus.done);
         end
      end
   endtask

   task automatic test_sra_srl;
      int cyc, bn;
      start_op(3'b011, 32'h8000_0010, 5'd4);
      wait_done(cyc, bn);
      checks++;
      if (bus.w_shiftOut !== 32'hF800_0001 || cyc !== 5) begin
         failures++;
         $display("FAIL sra: got %h at %0d want f8000001 at 5", bus.w_shiftOut, cyc);
      end
      @(posedge clock); #1;
      start_op(3'b010, 32'h8000_0010, 5'd4);
      wait_done(cyc, bn);
      checks++;
      if (bus.w_shiftOut !== 32'h0800_0001 || cyc !== 5) begin
         failures++;
         $display("FAIL srl: got %h at %0d want 08000001 at 5", bus.w_shiftOut, cyc);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_rotate;
      int cyc, bn;
      start_op(3'b100, 32'h0000_0001, 5'd1);
      wait_done(cyc, bn);
      checks++;
      if (bus.w_shiftOut !== 32'h8000_0000 || cyc !== 2) begin
         failures++;
         $display("FAIL ror1: got %h at %0d want 80000000 at 2", bus.w_shiftOut, cyc);
      end
      @(posedge clock); #1;
      start_op(3'b101, 32'h8000_0001, 5'd31);
      wait_done(cyc, bn);
      checks++;
      if (bus.w_shiftOut !== 32'hC000_0000 || cyc !== 32) begin
         failures++;
         $display("FAIL rol31: got %h at %0d want c0000000 at 32", bus.w_shiftOut, cyc);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_zero_shamt;
      int cyc, bn;
      logic [31:0] a;
      logic [2:0] o;
      for (int k = 0; k < 8; k++) begin
         o = 3'(k);
         a = 32'hA5C3_0F96 ^ 32'(k * 32'h0101_0101);
         start_op(o, a, 5'd0);
         wait_done(cyc, bn);
         checks++;
         if (bus.w_shiftOut !== a || cyc !== 1) begin
            failures++;
            $display("FAIL zero_shamt op%0d: got %h at %0d want %h at 1",
                     k, bus.w_shiftOut, cyc, a);
         end
         @(posedge clock); #1;
      end
      start_op(3'b110, 32'h1357_9BDF, 5'd3);
      wait_done(cyc, bn);
      checks++;
      if (bus.w_shiftOut !== 32'h1357_9BDF || cyc !== 4) begin
         failures++;
         $display("FAIL noop_timing: got %h at %0d want 13579bdf at 4", bus.w_shiftOut, cyc);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_ignored_starts;
      int cyc, bn;
      start_op(3'b001, 32'h0000_00F1, 5'd4);
      cyc = 0;
      bn = 0;
      for (int i = 1; i <= 64; i++) begin
         if (bus.busy) bn++;
         if (bus.done) begin
            cyc = i;
            break;
         end
         bus.start     = (i == 2);
         bus.w_shiftIn = 32'hDEAD_BEEF;
         bus.shamt     = 5'd1;
         bus.shiftOp   = 3'b010;
         @(posedge clock); #1;
      end
      bus.start     = 1'b1;
      bus.w_shiftIn = 32'h0000_1234;
      bus.shamt     = 5'd2;
      checks++;
      if (cyc !== 5 || bn !== 5 || bus.w_shiftOut !== 32'h0000_0F10) begin
         failures++;
         $display("FAIL ignore_shift: done at %0d busy %0d out %h want 5/5/00000f10",
                  cyc, bn, bus.w_shiftOut);
      end
      @(posedge clock); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.w_shiftOut !== 32'h0000_0F10) begin
            failures++;
            $display("FAIL ignore_done[%0d]: busy=%b done=%b out=%h want 0/0/00000f10",
                     i, bus.busy, bus.done, bus.w_shiftOut);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset_mid_shift;
      int cyc, bn;
      bit saw_done;
      start_op(3'b001, 32'h0000_0001, 5'd20);
      repeat (7) begin
         @(posedge clock); #1;
      end
      checks++;
      if (bus.w_shiftOut !== 32'h0000_0080 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_shift_value: out=%h busy=%b want 00000080/1",
                  bus.w_shiftOut, bus.busy);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.w_shiftOut !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL mid_shift_reset: out=%h busy=%b done=%b want 0/0/0",
                  bus.w_shiftOut, bus.busy, bus.done);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (bus.done || bus.busy) saw_done = 1'b1;
         @(posedge clock); #1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_done: activity after reset %b want 0", saw_done);
      end
      start_op(3'b001, 32'h0000_0003, 5'd2);
      wait_done(cyc, bn);
      checks++;
      if (bus.w_shiftOut !== 32'h0000_000C || cyc !== 3) begin
         failures++;
         $display("FAIL after_abort: got %h at %0d want 0000000c at 3", bus.w_shiftOut, cyc);
      end
      @(posedge clock); #1;
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.shiftOp   = 3'b000;
      bus.w_shiftIn = 32'h0;
      bus.shamt     = 5'd0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (bus.w_shiftOut !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL power_on_reset: out=%h busy=%b done=%b want 0/0/0",
                  bus.w_shiftOut, bus.busy, bus.done);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      test_reset();
      test_sll();
      test_sra_srl();
      test_rotate();
      test_zero_shamt();
      test_ignored_starts();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
